// File: rtl/key_pkg.sv
// Shared constants, FSM state encodings and the priority helper for the key scanner.
package key_pkg;

  localparam int NUM_KEYS         = 4;
  localparam int CODE_W           = 2;
  localparam int DEBOUNCE_DEFAULT = 500000;
  localparam int LONG_DEFAULT     = 50000000;
  localparam int CNT_W_DEFAULT    = 26;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } key_fsm_e;

  // Index of the lowest set bit; 0 when none are set.
  function automatic logic [CODE_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] bits);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (bits[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce_unit.sv
// One key: two-flop synchronizer, debounce counter and press FSM.
// Long-press detection is built only when KEY_LONGPRESS_EN is defined.
//
// state   | meaning
// IDLE    | key released, nothing in progress
// PRESSED | debounced press seen, waiting for release or long-press time
// LONG    | long event already raised, waiting for release
module key_debounce_unit
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int LONG_CYCLES     = LONG_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic level,
  output logic event_pulse
`ifdef KEY_LONGPRESS_EN
  ,
  output logic event_long
`endif
);

  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || CNT_W < 1 || CNT_W > 31 ||
      DEBOUNCE_CYCLES > (1 << CNT_W) || LONG_CYCLES > (1 << CNT_W)) begin : g_bad_params
    $error("key_debounce_unit: CNT_W too narrow for the cycle parameters");
  end

  logic [1:0]       sync_q;
  logic             pressed;
  logic [CNT_W-1:0] deb_cnt;
  logic             accept;
  logic             rise;
  logic             fall;
  key_fsm_e         state_q;
  key_fsm_e         state_d;

  // Synchronizer idles at the released (high) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], key_raw};
  end

  assign pressed = ~sync_q[1];
  assign accept  = (pressed != level) && (deb_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign rise    = accept & pressed;
  assign fall    = accept & ~pressed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt <= '0;
      level   <= 1'b0;
    end else if (pressed == level) begin
      deb_cnt <= '0;
    end else if (accept) begin
      deb_cnt <= '0;
      level   <= pressed;
    end else begin
      deb_cnt <= deb_cnt + CNT_W'(1);
    end
  end

`ifdef KEY_LONGPRESS_EN
  logic [CNT_W-1:0] hold_cnt;
  logic             hold_done;

  assign hold_done = (hold_cnt == CNT_W'(LONG_CYCLES - 1));

  // Zero on the entry edge, so it equals the number of cycles spent in PRESSED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    hold_cnt <= '0;
    else if (state_q == PRESSED) hold_cnt <= hold_cnt + CNT_W'(1);
    else                        hold_cnt <= '0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    event_pulse = 1'b0;
`ifdef KEY_LONGPRESS_EN
    event_long  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rise) state_d = PRESSED;
      end
      PRESSED: begin
        if (fall) begin
          state_d     = IDLE;
          event_pulse = 1'b1;
        end
`ifdef KEY_LONGPRESS_EN
        else if (hold_done) begin
          state_d     = LONG;
          event_pulse = 1'b1;
          event_long  = 1'b1;
        end
`endif
      end
`ifdef KEY_LONGPRESS_EN
      LONG: begin
        if (fall) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/key_scan_module.sv
// Four debounced keys with a lowest-index-first event arbiter and valid/ready handshake.
// Define KEY_LONGPRESS_EN to build long-press detection; otherwise KEY_Long is 0.
module key_scan_module
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int LONG_CYCLES     = LONG_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_KEYS-1:0] KEY_In,
  output logic [NUM_KEYS-1:0] KEY_State,
  output logic                KEY_Valid,
  output logic [CODE_W-1:0]   KEY_Code,
  output logic                KEY_Long,
  input  logic                KEY_Ready,
  output logic                KEY_Overrun
);

  logic [NUM_KEYS-1:0] ev;
  logic [NUM_KEYS-1:0] pending_q;
  logic [NUM_KEYS-1:0] pending_d;
  logic [NUM_KEYS-1:0] clr;
  logic [CODE_W-1:0]   code_q;
  logic                overrun_q;
  logic                accept;

`ifdef KEY_LONGPRESS_EN
  logic [NUM_KEYS-1:0] ev_long;
  logic [NUM_KEYS-1:0] long_q;
  logic [NUM_KEYS-1:0] long_d;
`endif

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce_unit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .CNT_W          (CNT_W)
    ) u_unit (
      .clk        (CLK),
      .rst        (RST),
      .key_raw    (KEY_In[k]),
      .level      (KEY_State[k]),
      .event_pulse(ev[k])
`ifdef KEY_LONGPRESS_EN
      ,
      .event_long (ev_long[k])
`endif
    );
  end

  assign KEY_Valid   = |pending_q;
  assign KEY_Code    = code_q;
  assign KEY_Overrun = overrun_q;
  assign accept      = KEY_Valid & KEY_Ready;

  // A new event on the key being accepted re-arms its bit instead of overrunning.
  always_comb begin
    clr       = accept ? (NUM_KEYS'(1) << code_q) : '0;
    pending_d = (pending_q & ~clr) | ev;
  end

`ifdef KEY_LONGPRESS_EN
  assign long_d   = (long_q & ~clr & ~ev) | (ev & ev_long);
  assign KEY_Long = long_q[code_q];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) long_q <= '0;
    else     long_q <= long_d;
  end
`else
  assign KEY_Long = 1'b0;
`endif

  // The presented code only moves when nothing is shown or the current event is taken.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending_q <= '0;
      code_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= |(ev & pending_q & ~clr);
      if (!KEY_Valid || accept) code_q <= lowest_set(pending_d);
    end
  end

endmodule

// File: tb/tb_key_scan_module.sv
// Self-checking bench for key_scan_module: directed scenarios plus random key traffic
// compared every cycle against a window-based behavioural model.
module tb_key_scan_module;
  import key_pkg::*;

  localparam int D  = 4;
  localparam int L  = 40;
  localparam int CW = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] KEY_In;
  logic [3:0] KEY_State;
  logic       KEY_Valid;
  logic [1:0] KEY_Code;
  logic       KEY_Long;
  logic       KEY_Ready;
  logic       KEY_Overrun;

  int total = 0;
  int bad   = 0;

  key_scan_module #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .CNT_W          (CW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .KEY_In     (KEY_In),
    .KEY_State  (KEY_State),
    .KEY_Valid  (KEY_Valid),
    .KEY_Code   (KEY_Code),
    .KEY_Long   (KEY_Long),
    .KEY_Ready  (KEY_Ready),
    .KEY_Overrun(KEY_Overrun)
  );

  always #10 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #5;
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Behavioural model: a level is accepted once the last D synchronized samples all
  // disagree with it; a press counts its age and raises short/long events.
  logic       hist [4][D+2];
  logic [3:0] mlvl;
  logic [3:0] mpend;
  logic [3:0] mlong;
  int         age [4];
  int         mpres;
  logic       movr;

  always @(posedge CLK or posedge RST) begin : model_blk
    logic [3:0] ev;
    logic [3:0] evl;
    logic       was_valid;
    logic       acc;
    logic       consumed;
    logic       all_diff;
    if (RST) begin
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < D + 2; i++) hist[k][i] = 1'b0;
        age[k] = -1;
      end
      mlvl  = '0;
      mpend = '0;
      mlong = '0;
      mpres = 0;
      movr  = 1'b0;
    end else begin
      ev  = '0;
      evl = '0;
      for (int k = 0; k < 4; k++) begin
        for (int i = D + 1; i > 0; i--) hist[k][i] = hist[k][i-1];
        hist[k][0] = !KEY_In[k];
        all_diff = 1'b1;
        for (int i = 2; i <= D + 1; i++) if (hist[k][i] == mlvl[k]) all_diff = 1'b0;
        if (all_diff) begin
          mlvl[k] = !mlvl[k];
          if (mlvl[k]) age[k] = 0;
          else begin
            if (age[k] >= 0) ev[k] = 1'b1;
            age[k] = -1;
          end
        end else if (age[k] >= 0) begin
          age[k]++;
`ifdef KEY_LONGPRESS_EN
          if (age[k] == L) begin
            ev[k]  = 1'b1;
            evl[k] = 1'b1;
            age[k] = -1;
          end
`endif
        end
      end
      was_valid = |mpend;
      acc       = was_valid && KEY_Ready;
      movr      = 1'b0;
      for (int k = 0; k < 4; k++) begin
        consumed = acc && (k == mpres);
        if (ev[k]) begin
          if (mpend[k] && !consumed) movr = 1'b1;
          mpend[k] = 1'b1;
          mlong[k] = evl[k];
        end else if (consumed) begin
          mpend[k] = 1'b0;
          mlong[k] = 1'b0;
        end
      end
      if (!was_valid || acc) mpres = lowest(mpend);
    end
  end

  always @(negedge CLK) begin
    chk("state", int'(KEY_State), int'(mlvl));
    chk("valid", int'(KEY_Valid), int'(|mpend));
    if (|mpend) chk("code", int'(KEY_Code), mpres);
    chk("long", int'(KEY_Long), (|mpend) ? int'(mlong[mpres]) : 0);
    chk("overrun", int'(KEY_Overrun), int'(movr));
  end

  int found;
  int saw;
  int ovr;
  int got_code;
  int got_long;
  int dur [4];

  initial begin
    RST       = 1'b1;
    KEY_In    = 4'hF;
    KEY_Ready = 1'b1;
    tick(10);
    chk("rst_state", int'(KEY_State), 0);
    chk("rst_valid", int'(KEY_Valid), 0);
    chk("rst_code", int'(KEY_Code), 0);
    chk("rst_long", int'(KEY_Long), 0);
    chk("rst_overrun", int'(KEY_Overrun), 0);
    RST = 1'b0;
    tick(5);

    // clean press on key 2
    KEY_In[2] = 1'b0;
    found = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (found < 0 && KEY_State[2]) found = i;
      if (i == 5) chk("model_before_rise", int'(mlvl[2]), 0);
      if (i == 6) chk("model_at_rise", int'(mlvl[2]), 1);
    end
    chk("press_latency", found, 6);
    KEY_In[2] = 1'b1;
    found = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (KEY_Valid) begin
        found = i;
        break;
      end
    end
    chk("release_latency", found, 6);
    chk("release_code", int'(KEY_Code), 2);
    chk("release_long", int'(KEY_Long), 0);
    tick(1);
    chk("release_one_shot", int'(KEY_Valid), 0);
    tick(5);

    // bounce on key 0
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      KEY_In[0] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick(1);
      if (KEY_Valid || KEY_State[0]) saw = 1;
    end
    KEY_In[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (KEY_Valid || KEY_State[0]) saw = 1;
    end
    chk("bounce_quiet", saw, 0);

    // long press on key 1
    KEY_In[1] = 1'b0;
    found = -1;
    got_code = -1;
    got_long = -1;
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      if (found < 0 && KEY_Valid) begin
        found    = i;
        got_code = int'(KEY_Code);
        got_long = int'(KEY_Long);
      end
    end
    KEY_In[1] = 1'b1;
`ifdef KEY_LONGPRESS_EN
    chk("long_latency", found, 46);
    chk("long_code", got_code, 1);
    chk("long_flag", got_long, 1);
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (KEY_Valid) saw = 1;
    end
    chk("long_release_quiet", saw, 0);
`else
    chk("held_no_event", found, -1);
    found = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (KEY_Valid) begin
        found = i;
        break;
      end
    end
    chk("long_release_latency", found, 6);
    chk("long_release_code", int'(KEY_Code), 1);
    chk("long_release_flag", int'(KEY_Long), 0);
    tick(5);
`endif

    // arbitration: keys 3 and 1 released together while the consumer is busy
    KEY_Ready = 1'b0;
    KEY_In    = 4'b0101;
    tick(12);
    KEY_In = 4'hF;
    found = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (KEY_Valid) begin
        found = i;
        break;
      end
    end
    chk("arb_latency", found, 6);
    chk("arb_first_code", int'(KEY_Code), 1);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("arb_hold_code", int'(KEY_Code), 1);
      chk("arb_hold_valid", int'(KEY_Valid), 1);
    end
    KEY_Ready = 1'b1;
    tick(1);
    chk("arb_second_valid", int'(KEY_Valid), 1);
    chk("arb_second_code", int'(KEY_Code), 3);
    tick(1);
    chk("arb_drained", int'(KEY_Valid), 0);

    // overrun: two presses of key 0 with no acceptance
    KEY_Ready = 1'b0;
    ovr = 0;
    repeat (2) begin
      KEY_In[0] = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick(1);
        if (KEY_Overrun) ovr++;
      end
      KEY_In[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick(1);
        if (KEY_Overrun) ovr++;
      end
    end
    chk("overrun_pulses", ovr, 1);
    chk("overrun_valid", int'(KEY_Valid), 1);
    chk("overrun_code", int'(KEY_Code), 0);
    KEY_Ready = 1'b1;
    tick(1);
    chk("overrun_single_event", int'(KEY_Valid), 0);

    // reset while key 2 is mid-debounce
    KEY_In[2] = 1'b0;
    tick(4);
    RST = 1'b1;
    tick(2);
    chk("midrst_state", int'(KEY_State), 0);
    chk("midrst_valid", int'(KEY_Valid), 0);
    chk("midrst_code", int'(KEY_Code), 0);
    chk("midrst_long", int'(KEY_Long), 0);
    chk("midrst_overrun", int'(KEY_Overrun), 0);
    RST = 1'b0;
    found = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (found < 0 && KEY_State[2]) found = i;
    end
    chk("post_reset_latency", found, 6);
    KEY_In[2] = 1'b1;
    tick(15);

    // random traffic: short bounces and holds of varying length, random ready
    for (int k = 0; k < 4; k++) dur[k] = int'($urandom_range(5, 70));
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (dur[k] == 0) begin
          KEY_In[k] = !KEY_In[k];
          dur[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(5, 70));
        end else begin
          dur[k]--;
        end
      end
      KEY_Ready = ($urandom_range(0, 3) != 0);
      if (c == 2000) RST = 1'b1;
      if (c == 2003) RST = 1'b0;
      tick(1);
    end
    KEY_In    = 4'hF;
    KEY_Ready = 1'b1;
    tick(100);
    chk("final_idle_valid", int'(KEY_Valid), 0);
    chk("final_idle_state", int'(KEY_State), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_scan_module.md
KEY_SCAN_MODULE -- requirements
Module: key_scan_module

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable samples needed to accept a key level change (10 ms at 50 MHz).
REQ-002 Parameter LONG_CYCLES, default 50000000, is the number of cycles a key must be held to count as a long press (1 s at 50 MHz).
REQ-003 Parameter CNT_W, default 26, is the counter width and SHALL hold max(DEBOUNCE_CYCLES, LONG_CYCLES).
REQ-004 Port CLK, input, 1 bit, is the single system clock; all logic runs on its rising edge.
REQ-005 Port RST, input, 1 bit, is an asynchronous, active-high reset.
REQ-006 Port KEY_In, input, 4 bits, carries the raw push-buttons; they are asynchronous and active-low (0 = pressed).
REQ-007 Port KEY_State, output, 4 bits, is the debounced level per key (1 = pressed).
REQ-008 Port KEY_Valid, output, 1 bit, indicates that a key event is pending.
REQ-009 Port KEY_Code, output, 2 bits, is the index of the presented event; it is valid only while KEY_Valid is 1.
REQ-010 Port KEY_Long, output, 1 bit, flags the presented event as a long press.
REQ-011 Port KEY_Ready, input, 1 bit; the consumer accepts the event when KEY_Valid and KEY_Ready are both 1.
REQ-012 Port KEY_Overrun, output, 1 bit, pulses for one cycle when an event is lost.

Function
REQ-013 Each KEY_In bit SHALL pass through a two-flop synchronizer and be inverted before any other use.
REQ-014 Per-key debounce counter:
- Counts while the synchronized level differs from KEY_State, and clears when the levels match.
- On reaching DEBOUNCE_CYCLES, KEY_State updates and the counter clears.
- Latency from input edge to KEY_State is 2 + DEBOUNCE_CYCLES cycles.
REQ-015 Per-key FSM with states IDLE, PRESSED, LONG:
- IDLE to PRESSED on a KEY_State rise.
- PRESSED to IDLE on a KEY_State fall, which sets that key's pending bit (short press).
- PRESSED to LONG (feature enabled) when the hold counter reaches LONG_CYCLES, which sets the pending bit with its long flag.
- LONG to IDLE on a KEY_State fall, with no further event.
REQ-016 KEY_Valid SHALL be the OR of the pending bits; KEY_Code and KEY_Long SHALL reflect the lowest-index pending key, registered with no combinational path from KEY_Ready.
REQ-017 On acceptance, the presented key's pending bit SHALL clear on the next edge, and the next-lowest pending key SHALL be presented in the following cycle.
REQ-018 KEY_Code and KEY_Long SHALL stay stable while KEY_Valid is 1 and KEY_Ready is 0, even if a lower-index key becomes pending.
REQ-019 If an event is raised for a key whose pending bit is already set, the bit SHALL stay set, its long flag SHALL take the new value, and KEY_Overrun SHALL pulse.
REQ-020 If an event is raised and accepted for the same key in the same cycle, the pending bit SHALL remain set (the new event wins) and KEY_Overrun SHALL stay 0.
REQ-021 Simultaneous events on different keys SHALL all be captured; none is lost.

Reset
REQ-022 While RST is 1:
- Synchronizers reset to the released level.
- Counters reset to 0, FSMs to IDLE, pending bits and long flags to 0.
- KEY_State = 0, KEY_Valid = 0, KEY_Code = 0, KEY_Long = 0, KEY_Overrun = 0.
REQ-023 RST asserted in mid-debounce or mid-hold SHALL discard the partial count; a key still held after reset release SHALL be debounced from scratch.

Configuration
REQ-024 Macro KEY_LONGPRESS_EN:
- Defined: hold counters, the LONG state and the long flags are built.
- Undefined: none of these exist, KEY_Long is tied to 0, and every press yields a short event on release.

Structure
REQ-025 Shared package key_pkg SHALL hold NUM_KEYS = 4, the FSM state encodings (IDLE = 0, PRESSED = 1, LONG = 2) and the default cycle constants.
REQ-026 A sub-module key_debounce_unit SHALL contain one key's synchronizer, debounce counter and FSM; it is instantiated four times, with the event arbiter in the top level.

Verification
REQ-027 The bench SHALL use a 20 ns clock, DEBOUNCE_CYCLES = 4 and LONG_CYCLES = 40, and SHALL hold RST = 1 for 10 cycles.
REQ-028 Clean press: KEY_In[2] = 0 for 20 cycles, then 1, KEY_Ready = 1 -> KEY_State[2] rises 6 cycles after the press; after release, KEY_Valid = 1 for one cycle with KEY_Code = 2 and KEY_Long = 0.
REQ-029 Bounce: KEY_In[0] toggles every 2 cycles for 20 cycles, then returns to 1 -> KEY_State stays 0 and KEY_Valid never rises.
REQ-030 Long press (macro defined): KEY_In[1] = 0 for 60 cycles -> KEY_Valid with KEY_Code = 1 and KEY_Long = 1 about 46 cycles after the press, and no event on release; with the macro undefined, a short event appears on release.
REQ-031 Arbitration: keys 3 and 1 released in the same cycle with KEY_Ready = 0, KEY_Ready raised 5 cycles later -> KEY_Code = 1 is held stable, then KEY_Code = 3 the cycle after acceptance, then KEY_Valid = 0.
REQ-032 Overrun and reset: key 0 pressed and released twice with KEY_Ready = 0 -> KEY_Overrun pulses once and a single event remains; then RST pulses while key 2 is held mid-debounce -> all outputs read 0 and KEY_State[2] rises 6 cycles after reset release.
